// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width and multiplier FSM encoding.
package mips_pkg;

    localparam int WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of Mx into A, then an
// arithmetic right shift of the combined {A, Q, q_m1} register.
module booth_step #(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH:0]   i_mx,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q_m1,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q_m1
);

    logic [WIDTH:0] w_sum;

    // Booth recoding of {Q[0], q_m1}, then the shift with A's MSB replicated
    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_q_m1})
            2'b01:   w_sum = i_a + i_mx;
            2'b10:   w_sum = i_a - i_mx;
            default: w_sum = i_a;
        endcase
        o_a    = {w_sum[WIDTH], w_sum[WIDTH:1]};
        o_q    = {w_sum[0], i_q[WIDTH-1:1]};
        o_q_m1 = i_q[0];
    end

endmodule

// File: rtl/booth_mult_unit.sv
// Sequential radix-2 Booth multiplier for the EX stage: one step per clock,
// signed WIDTH x WIDTH -> 2*WIDTH product held until the next completion.
module booth_mult_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   r_mx;
    logic [WIDTH-1:0] r_q;
    logic             r_q_m1;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_prod_hi;
    logic [WIDTH-1:0] r_prod_lo;

    logic [WIDTH:0]   w_a_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_q_m1_nxt;
    logic             w_accept;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_a    (r_a),
        .i_mx   (r_mx),
        .i_q    (r_q),
        .i_q_m1 (r_q_m1),
        .o_a    (w_a_nxt),
        .o_q    (w_q_nxt),
        .o_q_m1 (w_q_m1_nxt)
    );

    // A new request is taken only when the unit is not mid-operation
    always_comb begin
        if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
            w_accept = start;
        end else begin
            w_accept = 1'b0;
        end
    end

    // FSM, step counter, Booth working registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_mx      <= '0;
            r_q       <= '0;
            r_q_m1    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_a     <= '0;
                        r_mx    <= {multiplicand[WIDTH-1], multiplicand};
                        r_q     <= multiplier;
                        r_q_m1  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_a    <= w_a_nxt;
                    r_q    <= w_q_nxt;
                    r_q_m1 <= w_q_m1_nxt;
                    r_cnt  <= r_cnt + CW'(1);
                    // Final step: publish the post-shift product on this same edge
                    if (r_cnt == CNT_LAST) begin
                        r_prod_hi <= w_a_nxt[WIDTH-1:0];
                        r_prod_lo <= w_q_nxt;
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign product_hi = r_prod_hi;
    assign product_lo = r_prod_lo;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed and random checks of booth_mult_unit (WIDTH=32).
module tb_booth_mult_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int n_vec = 0;
    int n_err = 0;

    booth_mult_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Waits for done after an accept edge; lat = edges from accept to done
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            output logic [63:0] p, output int lat, output bit busy_ok);
        start = 1'b1;
        multiplicand = a;
        multiplier = b;
        tick();
        start = 1'b0;
        wait_done(lat, busy_ok);
        p = {product_hi, product_lo};
    endtask

    initial begin
        logic [63:0] p;
        logic [63:0] exp_p;
        int          lat;
        bit          busy_ok;
        bit          hold_ok;
        bit          seen_done;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1;
        start = 1'b0;
        multiplicand = 32'd0;
        multiplier = 32'd0;
        tick();
        tick();
        check_val("reset_busy", {63'd0, busy}, 64'd0);
        check_val("reset_done", {63'd0, done}, 64'd0);
        check_val("reset_prod", {product_hi, product_lo}, 64'd0);
        rst = 1'b0;
        tick();

        // 3 x -5
        run_mult(32'd3, 32'hFFFF_FFFB, p, lat, busy_ok);
        check_val("3x-5_prod", p, 64'hFFFF_FFFF_FFFF_FFF1);
        check_val("3x-5_lat", 64'(lat), 64'd32);
        check_val("3x-5_busy", {63'd0, busy_ok}, 64'd1);
        check_val("done_cycle_busy", {63'd0, busy}, 64'd0);
        tick();
        check_val("done_pulse_len", {63'd0, done}, 64'd0);
        check_val("prod_hold_idle", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        // Corner operands
        run_mult(32'h8000_0000, 32'h8000_0000, p, lat, busy_ok);
        check_val("min_x_min", p, 64'h4000_0000_0000_0000);
        tick();
        run_mult(32'h8000_0000, 32'hFFFF_FFFF, p, lat, busy_ok);
        check_val("min_x_m1", p, 64'h0000_0000_8000_0000);
        tick();
        run_mult(32'd0, 32'h7FFF_FFFF, p, lat, busy_ok);
        check_val("zero_x_max", p, 64'd0);
        tick();

        // start while busy is ignored
        start = 1'b1;
        multiplicand = 32'd7;
        multiplier = 32'd6;
        tick();
        start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (lat >= 5 && lat <= 8) begin
                start = 1'b1;
                multiplicand = 32'd2;
                multiplier = 32'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        check_val("ignore_start_prod", {product_hi, product_lo}, 64'd42);
        check_val("ignore_start_lat", 64'(lat), 64'd32);
        check_val("ignore_start_busy", {63'd0, busy_ok}, 64'd1);
        tick();
        check_val("ignore_start_idle", {62'd0, busy, done}, 64'd0);

        // rst mid-run aborts
        start = 1'b1;
        multiplicand = 32'd7;
        multiplier = 32'd6;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        check_val("abort_prod", {product_hi, product_lo}, 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        check_val("abort_no_done", {63'd0, seen_done}, 64'd0);

        // start held high: back-to-back, operands changed in the DONE cycle
        start = 1'b1;
        multiplicand = 32'd7;
        multiplier = 32'd6;
        tick();
        wait_done(lat, busy_ok);
        check_val("b2b_first_prod", {product_hi, product_lo}, 64'd42);
        check_val("b2b_first_lat", 64'(lat), 64'd32);
        multiplicand = 32'hFFFF_FFFC;
        multiplier = 32'd9;
        tick();
        check_val("b2b_reaccept_busy", {63'd0, busy}, 64'd1);
        lat = 0;
        hold_ok = 1'b1;
        while (!done && lat < 100) begin
            if ({product_hi, product_lo} !== 64'd42) hold_ok = 1'b0;
            tick();
            lat++;
        end
        check_val("b2b_hold_42", {63'd0, hold_ok}, 64'd1);
        check_val("b2b_second_prod", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFDC);
        check_val("b2b_second_lat", 64'(lat), 64'd32);
        start = 1'b0;
        tick();

        // Random pairs against the behavioural signed product
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            exp_p = 64'($signed(ra) * $signed(rb));
            run_mult(ra, rb, p, lat, busy_ok);
            check_val("random", p, exp_p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
